// File: rtl/bcd_to_binary_if.sv
// bcd_to_binary_if
//   Request/result bundle for the packed-BCD to binary converter.
//   master : requester (drives start/bcd_in, observes result and status)
//   slave  : converter (observes start/bcd_in, drives result and status)
// Signals
//   start   request a conversion
//   bcd_in  packed BCD operand, digit k at [4k+3:4k], digit 0 least significant
//   binary  converted value, valid with done and held until the next accepted start
//   busy    conversion in progress
//   done    one-cycle pulse, result and flags valid
//   bcd_err a nibble above 9 was seen
//   ovf     value did not fit in WIDTH bits
interface bcd_to_binary_if #(
  parameter int unsigned DIGITS = 11,
  parameter int unsigned WIDTH  = 36
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [WIDTH-1:0]      binary;
  logic                  busy;
  logic                  done;
  logic                  bcd_err;
  logic                  ovf;

  modport master (
    output start, bcd_in,
    input  binary, busy, done, bcd_err, ovf
  );

  modport slave (
    input  start, bcd_in,
    output binary, busy, done, bcd_err, ovf
  );
endinterface

// File: rtl/bcd_to_binary.sv
// bcd_to_binary
//   Sequential decoder from DIGITS packed BCD digits to a WIDTH-bit unsigned
//   value. Iterative multiply-by-10-and-add, one digit per clock, most
//   significant digit first. Sits between the keypad/display digit registers
//   and the arithmetic datapath.
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high; overrides everything, even mid-conversion
//   bus    bcd_to_binary_if.slave (start, bcd_in in; binary, busy, done,
//          bcd_err, ovf out)
// Timing
//   start accepted at edge E (in IDLE or DONE) -> busy for DIGITS cycles ->
//   done pulses in the cycle after edge E+DIGITS. A start seen in DONE begins
//   the next conversion immediately, giving one result every DIGITS+1 cycles.
module bcd_to_binary #(
  parameter int unsigned DIGITS = 11,
  parameter int unsigned WIDTH  = 36
) (
  input logic          clk,
  input logic          reset,
  bcd_to_binary_if.slave bus
);

  // Four guard bits: acc*10+15 never exceeds 2^(WIDTH+4) while acc < 2^WIDTH.
  localparam int unsigned AW = WIDTH + 4;
  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t         state;
  logic [SW-1:0]  sr;    // captured operand, shifted left one digit per step
  logic [AW-1:0]  acc;
  logic [CW-1:0]  cnt;

  logic [3:0]     digit;
  logic [AW-1:0]  acc_mul;
  logic [AW-1:0]  acc_next;
  logic           acc_big;
  logic           err_next;
  logic           ovf_next;

  always_comb begin
    digit    = sr[SW-1 -: 4];
    acc_mul  = (acc << 3) + (acc << 1) + AW'(digit);
    acc_big  = |acc_mul[AW-1:WIDTH];
    err_next = bus.bcd_err | (digit > 4'd9);
    ovf_next = bus.ovf | acc_big;
    // Freeze the accumulator once overflow is seen so it can never wrap.
    acc_next = ovf_next ? acc : acc_mul;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      acc         <= '0;
      cnt         <= '0;
      bus.binary  <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.bcd_err <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            sr          <= bus.bcd_in;
            acc         <= '0;
            cnt         <= CW'(DIGITS - 1);
            bus.bcd_err <= 1'b0;
            bus.ovf     <= 1'b0;
            bus.binary  <= '0;
            bus.busy    <= 1'b1;
            state       <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end

        CONVERT: begin
          sr          <= sr << 4;
          acc         <= acc_next;
          bus.bcd_err <= err_next;
          bus.ovf     <= ovf_next;
          if (cnt == '0) begin
            // Result registered from the final step's combinational values.
            bus.binary <= (err_next | ovf_next) ? '0 : acc_next[WIDTH-1:0];
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
